// File: rtl/imem_responder.sv
// Instruction memory responder: single-outstanding fetch port with fixed
// wait states, fault detection and a side-band program-load write port.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_instr_o,
    output logic        rsp_err_o,
    output logic [31:0] rsp_addr_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_instr_q;
    logic        rsp_err_q;
    logic [31:0] rsp_addr_q;

    logic        fault_d;
    logic        wr_hit_d;
    logic        unused_wr_lsb;

    assign unused_wr_lsb = ^wr_addr_i[1:0];

    always_comb begin
        fault_d  = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);
        wr_hit_d = wr_en_i && (wr_addr_i[31:2] < DEPTH_W);
    end

    // Reset keeps the array contents but drops a coincident write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_hit_d) begin
            mem[wr_addr_i[AW+1:2]] <= wr_data_i;
        end
    end

    // The first RESP cycle performs the array read; rsp_valid_q marks
    // that the held response is registered and presented.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_addr_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        cnt_q   <= '0;
                        state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= fault_d;
                        rsp_addr_q  <= addr_q;
                        rsp_instr_q <= fault_d ? NOP
                                               : mem[addr_q[AW+1:2]];
                    end else if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_instr_o = rsp_instr_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_addr_o  = rsp_addr_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: vector table, random fetches against a
// word-array model, and hand-built reset / write-collision / zero-wait cases.
module tb_imem_responder;

    localparam int DEPTH = 64;
    localparam int W = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, wr_en;
    logic [31:0] req_addr, rsp_instr, rsp_addr, wr_addr, wr_data;
    logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready;
    logic        z_rsp_err, z_wr_en;
    logic [31:0] z_req_addr, z_rsp_instr, z_rsp_addr, z_wr_addr, z_wr_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] mdl [DEPTH];

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_instr_o(rsp_instr), .rsp_err_o(rsp_err),
        .rsp_addr_o(rsp_addr),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
    );

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(z_req_valid), .req_ready_o(z_req_ready),
        .req_addr_i(z_req_addr),
        .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready),
        .rsp_instr_o(z_rsp_instr), .rsp_err_o(z_rsp_err),
        .rsp_addr_o(z_rsp_addr),
        .wr_en_i(z_wr_en), .wr_addr_i(z_wr_addr), .wr_data_i(z_wr_data)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_wr(input logic [31:0] a, input logic [31:0] d);
        if ((a >> 2) < DEPTH) mdl[int'(a >> 2)] = d;
    endtask

    function automatic void exp_rsp(input logic [31:0] a,
                                    output logic [31:0] ins,
                                    output logic e);
        e = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
        if (e) ins = NOP;
        else ins = mdl[int'(a >> 2)];
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick;
        wr_en = 1'b0;
        mdl_wr(a, d);
    endtask

    // One fetch: optional write at edge 'wo' counted from the handshake
    // edge (0), then 'hold' stalled cycles before the response is taken.
    task automatic do_req(input logic [31:0] a, input logic [31:0] ei,
                          input logic ee, input int hold, input bit hw,
                          input int wo, input logic [31:0] wa,
                          input logic [31:0] wd);
        int lat;
        logic [31:0] hd;
        lat = -1;
        chk1("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr = a;
        rsp_ready = 1'b0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            if (k == 1) begin
                req_valid = 1'b0;
                req_addr = $urandom;
            end
            wr_en = (k == wo);
            wr_addr = wa;
            wr_data = wd;
            tick;
            if (k == wo) mdl_wr(wa, wd);
            if (k == 0) chk1("req_ready_busy", req_ready, 1'b0);
            if (rsp_valid) lat = k;
        end
        wr_en = 1'b0;
        req_valid = 1'b0;
        chk("latency", lat, W + 1);
        if (lat < 0) return;
        chk("rsp_instr", rsp_instr, ei);
        chk1("rsp_err", rsp_err, ee);
        chk("rsp_addr", rsp_addr, a);
        for (int h = 0; h < hold; h++) begin
            hd = $urandom;
            wr_en = hw && (h == 0);
            wr_addr = a;
            wr_data = hd;
            tick;
            if (hw && h == 0) mdl_wr(a, hd);
            wr_en = 1'b0;
            chk1("hold_valid", rsp_valid, 1'b1);
            chk1("hold_ready", req_ready, 1'b0);
            chk("hold_instr", rsp_instr, ei);
            chk1("hold_err", rsp_err, ee);
            chk("hold_addr", rsp_addr, a);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk1("rel_valid", rsp_valid, 1'b0);
        chk1("rel_ready", req_ready, 1'b1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          hold;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        vec_t tbl[9];
        logic [31:0] a, wa, wd, ei;
        logic ee;
        int hold, wo, pulses, sel;
        bit hw;
        logic [31:0] zexp[2];
        logic [31:0] zadr[2];
        int hs_e[2];
        int nh, nr;
        logic prevv, hs;

        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        z_req_valid = 1'b0; z_req_addr = '0; z_rsp_ready = 1'b0;
        z_wr_en = 1'b0; z_wr_addr = '0; z_wr_data = '0;
        tick;
        tick;
        chk1("rst_valid", rsp_valid, 1'b0);
        chk("rst_instr", rsp_instr, 32'h0);
        chk1("rst_err", rsp_err, 1'b0);
        chk("rst_addr", rsp_addr, 32'h0);
        rst = 1'b0;
        chk1("rst_ready", req_ready, 1'b1);

        for (int i = 0; i < DEPTH; i++) wr(32'(i * 4), $urandom);
        wr(32'h0, 32'h0050_0093);
        wr(32'h4, 32'h0010_0113);
        wr(32'(4 * (DEPTH - 1)), 32'h0FF0_0F93);

        tbl[0] = '{32'h0, 32'h0050_0093, 1'b0, 0};
        tbl[1] = '{32'h4, 32'h0010_0113, 1'b0, 2};
        tbl[2] = '{32'h2, NOP, 1'b1, 0};
        tbl[3] = '{32'(4 * DEPTH), NOP, 1'b1, 1};
        tbl[4] = '{32'(4 * (DEPTH - 1)), 32'h0FF0_0F93, 1'b0, 0};
        tbl[5] = '{32'h1, NOP, 1'b1, 0};
        tbl[6] = '{32'hFFFF_FFFC, NOP, 1'b1, 0};
        tbl[7] = '{32'h0, 32'h0050_0093, 1'b0, 5};
        tbl[8] = '{32'(4 * (DEPTH - 1) + 3), NOP, 1'b1, 5};
        foreach (tbl[i]) begin
            do_req(tbl[i].addr, tbl[i].instr, tbl[i].err,
                   tbl[i].hold, 1'b0, -1, 32'h0, 32'h0);
        end

        exp_rsp(32'd20, ei, ee);
        do_req(32'd20, ei, ee, 0, 1'b0, W + 1, 32'd20, 32'hDEAD_BEEF);
        do_req(32'd20, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, -1, 32'h0, 32'h0);
        do_req(32'd24, 32'hCAFE_F00D, 1'b0, 0, 1'b0, W, 32'd24,
               32'hCAFE_F00D);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    wr(32'(4 * DEPTH) + ($urandom & 32'h0000_FFFC),
                       $urandom);
                else
                    wr(32'($urandom_range(0, DEPTH - 1) * 4), $urandom);
            end
            sel = int'($urandom_range(0, 3));
            if (sel < 2)
                a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel == 2)
                a = 32'($urandom_range(0, DEPTH - 1) * 4
                        + $urandom_range(1, 3));
            else
                a = 32'(4 * DEPTH) + ($urandom & 32'h0FFF_FFFF);
            hold = int'($urandom_range(0, 3));
            hw = 1'($urandom_range(0, 1));
            wo = ($urandom_range(0, 1) == 1)
                 ? int'($urandom_range(0, W + 1)) : -1;
            wa = ($urandom_range(0, 1) == 1)
                 ? a : 32'($urandom_range(0, DEPTH - 1) * 4);
            wd = $urandom;
            exp_rsp(a, ei, ee);
            if (wo >= 0 && wo <= W && !ee && (wa >> 2) == (a >> 2))
                ei = wd;
            do_req(a, ei, ee, hold, hw, wo, wa, wd);
            repeat ($urandom_range(0, 2)) tick;
        end

        req_valid = 1'b1;
        req_addr = 32'd8;
        tick;
        req_valid = 1'b0;
        chk1("rstw_busy", req_ready, 1'b0);
        rst = 1'b1;
        req_valid = 1'b1;
        wr_en = 1'b1;
        wr_addr = 32'd8;
        wr_data = 32'hBAD0_0001;
        tick;
        rst = 1'b0;
        wr_en = 1'b0;
        req_valid = 1'b0;
        chk1("rstw_valid", rsp_valid, 1'b0);
        chk("rstw_instr", rsp_instr, 32'h0);
        chk1("rstw_err", rsp_err, 1'b0);
        chk("rstw_addr", rsp_addr, 32'h0);
        chk1("rstw_ready", req_ready, 1'b1);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (rsp_valid) pulses++;
        end
        chk("rstw_pulses", pulses, 0);
        exp_rsp(32'd8, ei, ee);
        do_req(32'd8, ei, ee, 0, 1'b0, -1, 32'h0, 32'h0);

        z_wr_en = 1'b1;
        z_wr_addr = 32'h0;
        z_wr_data = 32'h0050_0093;
        tick;
        z_wr_addr = 32'h4;
        z_wr_data = 32'h0010_0113;
        tick;
        z_wr_en = 1'b0;
        zexp[0] = 32'h0050_0093;
        zexp[1] = 32'h0010_0113;
        zadr[0] = 32'h0;
        zadr[1] = 32'h4;
        hs_e[0] = 0;
        hs_e[1] = 0;
        nh = 0;
        nr = 0;
        prevv = 1'b0;
        z_rsp_ready = 1'b1;
        z_req_valid = 1'b1;
        z_req_addr = 32'h0;
        for (int k = 0; k < 20; k++) begin
            hs = z_req_valid && z_req_ready;
            tick;
            if (hs) begin
                hs_e[nh] = k;
                nh++;
                if (nh == 2) z_req_valid = 1'b0;
                else z_req_addr = 32'h4;
            end
            if (z_rsp_valid && !prevv && nr < 2) begin
                chk("z_latency", k - hs_e[nr], 1);
                chk("z_instr", z_rsp_instr, zexp[nr]);
                chk1("z_err", z_rsp_err, 1'b0);
                chk("z_addr", z_rsp_addr, zadr[nr]);
                nr++;
            end
            prevv = z_rsp_valid;
        end
        z_req_valid = 1'b0;
        z_rsp_ready = 1'b0;
        chk("z_nresp", nr, 2);
        chk("z_spacing", hs_e[1] - hs_e[0], 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
